// File: rtl/cic_array_sequencer.sv
// Timing and readout controller for the PDM/CIC decimator array: PDM clock, CIC strobes,
// per-frame channel capture and valid/ready streaming. Define CIC_SEQ_CHMASK_EN for ch_mask.
module cic_array_sequencer #(
  parameter int unsigned NUM_CH    = 16,
  parameter int unsigned OUT_W     = 19,
  parameter int unsigned CLK_DIV   = 8,
  parameter int unsigned DEC_RATIO = 64,
  parameter int unsigned CAP_DLY   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [NUM_CH*OUT_W-1:0]     ch_data,
`ifdef CIC_SEQ_CHMASK_EN
  input  logic [NUM_CH-1:0]           ch_mask,
`endif
  output logic                        pdm_clk,
  output logic                        pdm_ce,
  output logic                        dec_ce,
  output logic [OUT_W-1:0]            m_data,
  output logic [$clog2(NUM_CH)-1:0]   m_ch,
  output logic                        m_sof,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        clr_overrun
);

  localparam int unsigned ChW  = $clog2(NUM_CH);
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned DecW = (DEC_RATIO > 1) ? $clog2(DEC_RATIO) : 1;
  localparam int unsigned DlyW = $clog2(CAP_DLY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StStream} state_e;

  state_e                    state_q;
  logic [DivW-1:0]           div_cnt_q;
  logic [DecW-1:0]           dec_cnt_q;
  logic [DlyW-1:0]           dly_q;
  logic [ChW-1:0]            idx_q;
  logic [NUM_CH*OUT_W-1:0]   shadow_q;
  logic [NUM_CH-1:0]         mask_q;
  logic [NUM_CH-1:0]         cap_mask;
  logic                      pdm_clk_q, pdm_ce_q, dec_ce_q;
  logic [OUT_W-1:0]          m_data_q;
  logic [ChW-1:0]            m_ch_q;
  logic                      m_sof_q, m_valid_q, overrun_q;
  logic                      first_found, next_found;
  logic [ChW-1:0]            first_idx, next_idx;

`ifdef CIC_SEQ_CHMASK_EN
  assign cap_mask = ch_mask;
`else
  assign cap_mask = '1;
`endif

  // Lowest enabled channel at capture, and next enabled channel above idx during streaming.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (cap_mask[i]) begin
        first_found = 1'b1;
        first_idx   = ChW'(i);
      end
      if (mask_q[i] && (ChW'(i) > idx_q)) begin
        next_found = 1'b1;
        next_idx   = ChW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      dec_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
      pdm_ce_q  <= 1'b0;
      dec_ce_q  <= 1'b0;
    end else if (!run) begin
      div_cnt_q <= '0;
      dec_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
      pdm_ce_q  <= 1'b0;
      dec_ce_q  <= 1'b0;
    end else begin
      div_cnt_q <= (div_cnt_q == DivW'(CLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
      pdm_clk_q <= (div_cnt_q < DivW'(CLK_DIV / 2));
      pdm_ce_q  <= (div_cnt_q == '0);
      dec_ce_q  <= (div_cnt_q == '0) && (dec_cnt_q == DecW'(DEC_RATIO - 1));
      if (div_cnt_q == '0) begin
        dec_cnt_q <= (dec_cnt_q == DecW'(DEC_RATIO - 1)) ? '0 : dec_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      dly_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      mask_q    <= '0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
      m_sof_q   <= 1'b0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // A strobe while a frame is in flight drops the new frame; set beats clear.
      if (dec_ce_q && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (dec_ce_q) begin
            state_q <= StWait;
            dly_q   <= DlyW'(CAP_DLY);
          end
        end
        StWait: begin
          if (dly_q <= DlyW'(1)) begin
            shadow_q  <= ch_data;
            mask_q    <= cap_mask;
            idx_q     <= first_idx;
            m_data_q  <= ch_data[first_idx*OUT_W +: OUT_W];
            m_ch_q    <= first_idx;
            m_sof_q   <= first_found;
            m_valid_q <= first_found;
            state_q   <= first_found ? StStream : StIdle;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        StStream: begin
          if (m_valid_q && m_ready) begin
            if (next_found) begin
              idx_q    <= next_idx;
              m_data_q <= shadow_q[next_idx*OUT_W +: OUT_W];
              m_ch_q   <= next_idx;
              m_sof_q  <= 1'b0;
            end else begin
              m_valid_q <= 1'b0;
              m_sof_q   <= 1'b0;
              state_q   <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pdm_clk = pdm_clk_q;
  assign pdm_ce  = pdm_ce_q;
  assign dec_ce  = dec_ce_q;
  assign m_data  = m_data_q;
  assign m_ch    = m_ch_q;
  assign m_sof   = m_sof_q;
  assign m_valid = m_valid_q;
  assign busy    = (state_q != StIdle);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_cic_array_sequencer.sv
// Randomized bench for cic_array_sequencer: a cycle-level timing model plus a frame queue
// scoreboard for the readout stream.
module tb_cic_array_sequencer;

  localparam int NUM_CH    = 16;
  localparam int OUT_W     = 19;
  localparam int CLK_DIV   = 8;
  localparam int DEC_RATIO = 64;
  localparam int CAP_DLY   = 2;
  localparam int ChW       = $clog2(NUM_CH);

  typedef struct packed {
    logic [ChW-1:0]   ch;
    logic [OUT_W-1:0] data;
    logic             sof;
  } word_t;

  logic                    clk = 1'b0;
  logic                    rst, run, m_ready, clr_overrun;
  logic [NUM_CH*OUT_W-1:0] ch_data;
  logic [NUM_CH-1:0]       mask;
  logic                    pdm_clk, pdm_ce, dec_ce, m_sof, m_valid, busy, overrun;
  logic [OUT_W-1:0]        m_data;
  logic [ChW-1:0]          m_ch;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  word_t exp_q[$];
  int    ph      = -1;
  int    pending = 0;
  bit    exp_ovr = 1'b0;
  bit    exp_dec = 1'b0;

  cic_array_sequencer #(
    .NUM_CH(NUM_CH), .OUT_W(OUT_W), .CLK_DIV(CLK_DIV), .DEC_RATIO(DEC_RATIO), .CAP_DLY(CAP_DLY)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .ch_data(ch_data),
`ifdef CIC_SEQ_CHMASK_EN
    .ch_mask(mask),
`endif
    .pdm_clk(pdm_clk), .pdm_ce(pdm_ce), .dec_ce(dec_ce), .m_data(m_data), .m_ch(m_ch),
    .m_sof(m_sof), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_busy();
    return (pending > 0) || (exp_q.size() > 0);
  endfunction

  function automatic logic [NUM_CH*OUT_W-1:0] rand_data();
    logic [NUM_CH*OUT_W-1:0] d;
    for (int k = 0; k < NUM_CH; k++) d[k*OUT_W +: OUT_W] = OUT_W'($urandom);
    return d;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_pdm_clk"}, 32'(pdm_clk), 32'd0);
    check({pfx, "_pdm_ce"},  32'(pdm_ce),  32'd0);
    check({pfx, "_dec_ce"},  32'(dec_ce),  32'd0);
    check({pfx, "_m_data"},  32'(m_data),  32'd0);
    check({pfx, "_m_ch"},    32'(m_ch),    32'd0);
    check({pfx, "_m_sof"},   32'(m_sof),   32'd0);
    check({pfx, "_m_valid"}, 32'(m_valid), 32'd0);
    check({pfx, "_busy"},    32'(busy),    32'd0);
    check({pfx, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Model: PDM timing from cycles-since-run, readout as a queue of expected words.
  always @(posedge clk) begin
    bit                      run_s, rdy_s, clr_s, busy_pre, prev_dec, first;
    logic [NUM_CH*OUT_W-1:0] data_s;
    logic [NUM_CH-1:0]       mask_s;
    word_t                   w;
    run_s  = run;
    rdy_s  = m_ready;
    clr_s  = clr_overrun;
    data_s = ch_data;
`ifdef CIC_SEQ_CHMASK_EN
    mask_s = mask;
`else
    mask_s = '1;
`endif
    if (!rst) begin
      exp_q.delete();
      ph      = -1;
      pending = 0;
      exp_ovr = 1'b0;
      exp_dec = 1'b0;
    end else begin
      busy_pre = model_busy();
      prev_dec = exp_dec;
      if (exp_q.size() > 0 && rdy_s) void'(exp_q.pop_front());
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          first = 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            if (mask_s[k]) begin
              w.ch   = ChW'(k);
              w.data = data_s[k*OUT_W +: OUT_W];
              w.sof  = first;
              first  = 1'b0;
              exp_q.push_back(w);
            end
          end
        end
      end
      if (prev_dec && busy_pre) exp_ovr = 1'b1;
      else if (clr_s) exp_ovr = 1'b0;
      if (prev_dec && !busy_pre) pending = CAP_DLY;
      ph      = run_s ? ph + 1 : -1;
      exp_dec = (ph >= 0) && (ph % CLK_DIV == 0) && ((ph / CLK_DIV) % DEC_RATIO == DEC_RATIO - 1);
      #1;
      check("pdm_clk", 32'(pdm_clk), 32'((ph >= 0) && (ph % CLK_DIV < CLK_DIV / 2)));
      check("pdm_ce",  32'(pdm_ce),  32'((ph >= 0) && (ph % CLK_DIV == 0)));
      check("dec_ce",  32'(dec_ce),  32'(exp_dec));
      check("busy",    32'(busy),    32'(model_busy()));
      check("overrun", 32'(overrun), 32'(exp_ovr));
      check("m_valid", 32'(m_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("m_ch",   32'(m_ch),   32'(exp_q[0].ch));
        check("m_data", 32'(m_data), 32'(exp_q[0].data));
        check("m_sof",  32'(m_sof),  32'(exp_q[0].sof));
      end
    end
  end

  initial begin
    int n;
    rst         = 1'b0;
    run         = 1'b0;
    m_ready     = 1'b1;
    clr_overrun = 1'b0;
    mask        = '1;
    for (int k = 0; k < NUM_CH; k++) ch_data[k*OUT_W +: OUT_W] = OUT_W'(k * 'h101);
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Fixed ramp pattern, always ready
    rst = 1'b1;
    run = 1'b1;
    repeat (1100) @(negedge clk);

    // Random data every cycle (exercises the shadow register)
    repeat (1100) @(negedge clk) ch_data = rand_data();

    // Ready toggling 1-0-1-0
    repeat (1100) @(negedge clk) begin
      ch_data = rand_data();
      m_ready = ~m_ready;
    end

    // Random backpressure
    repeat (1100) @(negedge clk) begin
      ch_data = rand_data();
      m_ready = ($urandom_range(0, 3) != 0);
    end

    // Stall across a second strobe to force an overrun, then drain and clear
    m_ready = 1'b0;
    repeat (1100) @(negedge clk);
    check("ovr_after_stall", 32'(overrun), 32'd1);
    m_ready = 1'b1;
    repeat (40) @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Clear coinciding with a strobe while busy: set wins
    m_ready = 1'b0;
    n = 0;
    while (!(exp_dec && model_busy()) && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("clr_wait_bound", 32'(n < 1200), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'd1);
    m_ready = 1'b1;
    repeat (100) @(negedge clk);

    // Deassert run mid-stream
    n = 0;
    while (exp_q.size() != 8 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("run_wait_bound", 32'(n < 1200), 32'd1);
    run = 1'b0;
    repeat (40) @(negedge clk);
    check("run_off_pdm_clk", 32'(pdm_clk), 32'd0);
    check("run_off_busy",    32'(busy),    32'd0);
    run = 1'b1;
    repeat (1100) @(negedge clk) ch_data = rand_data();

`ifdef CIC_SEQ_CHMASK_EN
    mask = 16'h8421;
    repeat (600) @(negedge clk) ch_data = rand_data();
    mask = '0;
    repeat (600) @(negedge clk) ch_data = rand_data();
    mask = NUM_CH'($urandom);
    repeat (600) @(negedge clk) ch_data = rand_data();
    mask = '1;
`endif

    // Asynchronous reset mid-stream
    n = 0;
    while (exp_q.size() < 5 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_bound", 32'(n < 1200), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (600) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
